pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 16-bit five-stage pipeline.
- Drives the enable (via stall) and bubble-insert (via flush) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable.
- Arbitrates load-use hazards, branch redirects, instruction-memory and data-memory busy handshakes, and processor halt.
- A small FSM tracks multi-cycle memory waits and the halted condition.

Parameters:
REG_AW, 3, register-specifier width.
CNT_W, 16, width of the optional performance counters.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
id_rs  in  REG_AW  source register 1 of the instruction in ID.
id_rt  in  REG_AW  source register 2 of the instruction in ID.
id_rs_vld  in  1  id_rs is actually read.
id_rt_vld  in  1  id_rt is actually read.
ex_rd  in  REG_AW  destination register of the instruction in EX.
ex_regwr  in  1  the EX instruction writes a register.
ex_memrd  in  1  the EX instruction is a load.
br_taken  in  1  EX resolved a taken branch or jump.
imem_busy  in  1  instruction memory has not returned the fetch.
dmem_busy  in  1  data memory request in MEM is pending.
dmem_done  in  1  data memory request completes this cycle.
wb_halt  in  1  HALT instruction is in WB.
pc_en  out  1  PC register write enable.
stall_if_id  out  1  hold IF/ID.
stall_id_ex  out  1  hold ID/EX.
stall_ex_mem  out  1  hold EX/MEM.
stall_mem_wb  out  1  hold MEM/WB.
flush_if_id  out  1  load a bubble into IF/ID.
flush_id_ex  out  1  load a bubble into ID/EX.
halted  out  1  processor halted.

Behaviour:
- FSM states: RUN, DWAIT, HALT.
- Reset: state=RUN. During reset all outputs are 0, except pc_en, which is 0 while rst is high. After reset release, outputs follow the RUN equations.
- Outputs are combinational from state and inputs; only the state register is clocked.

Priority within RUN, highest first:
1. wb_halt
   - Next state HALT.
   - This cycle: all stall_* =1, pc_en=0, no flush.
2. dmem_busy && !dmem_done
   - Next state DWAIT.
   - This cycle: all four stall_* =1, pc_en=0, flushes=0.
3. br_taken
   - pc_en=1, flush_if_id=1, flush_id_ex=1, no stalls.
   - Branch overrides imem_busy: the in-flight fetch is discarded.
   - Branch overrides a load-use match, since the ID instruction is squashed.
4. Load-use
   - Condition: ex_memrd && ex_regwr && ((id_rs_vld && id_rs==ex_rd) || (id_rt_vld && id_rt==ex_rd)).
   - Response: pc_en=0, stall_if_id=1, flush_id_ex=1 (exactly one bubble per match).
5. imem_busy
   - pc_en=0, stall_if_id=0, flush_if_id=1: a bubble enters ID while the fetch is outstanding.
   - Downstream stages keep flowing.
6. Otherwise: pc_en=1, all stall/flush =0.

DWAIT:
- All four stall_* =1, pc_en=0, flushes=0.
- On dmem_done, the stalls still apply that cycle and the next state is RUN.
- EX is frozen, so br_taken is held and gets serviced on the first RUN cycle.

HALT:
- All stall_* =1, pc_en=0, halted=1.
- Only rst leaves HALT.

Other rules:
- dmem_done with dmem_busy in the same RUN cycle is treated as a single-cycle access: no stall.
- Register 0 is not special-cased; a match on r0 still stalls.
- Flush and stall on the same register are never both asserted.
- Asserting rst in any state returns to RUN immediately and aborts any DWAIT.

Optional Feature:
PIPE_PERF_CNT_EN
- With the macro defined, the block adds these outputs, all reset to 0:
  - stall_cyc [CNT_W]: counts cycles with pc_en=0 while not halted.
  - luse_cnt [CNT_W]: counts load-use bubbles.
  - flush_cnt [CNT_W]: counts branch flushes.
- Counters saturate at all-ones and freeze in HALT.
- Without the macro, the ports and logic are absent.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding typedef (RUN=2'b00, DWAIT=2'b01, HALT=2'b10);
  - REG_AW;
  - the stall/flush vector bit-index constants.
- One natural sub-module is pipe_luse_detect: the combinational load-use comparator.
- The FSM and the optional counters stay in the top module.

Test Plan:
- Load-use:
  - Stimulus: ex_memrd=1, ex_regwr=1, ex_rd=3, id_rs=3, id_rs_vld=1.
  - Response: pc_en=0, stall_if_id=1, flush_id_ex=1 for 1 cycle.
  - With id_rs_vld=0, no stall.
- Branch over hazard:
  - Stimulus: br_taken=1 together with the load-use match and imem_busy=1.
  - Response: pc_en=1, flush_if_id=1, flush_id_ex=1, no stalls.
- Data memory wait:
  - Stimulus: dmem_busy=1 for 4 cycles, dmem_done on the 4th.
  - Response: all stalls =1 for 4 cycles, then RUN with pc_en=1.
  - A br_taken held throughout is serviced on cycle 5.
- Instruction memory busy:
  - Stimulus: imem_busy=1 for 3 cycles.
  - Response: flush_if_id=1 and pc_en=0 for 3 cycles; stall_mem_wb=0.
- Halt:
  - Stimulus: wb_halt pulse.
  - Response: halted=1 and all stalls =1 permanently.
  - Async rst mid-cycle: outputs clear immediately, and state reads RUN after rst falls.
- Performance counters (macro defined):
  - Stimulus: 2 load-use events + 1 flush.
  - Response: luse_cnt=2, flush_cnt=1, stall_cyc=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, register width, stall/flush bit indices.
package pipe_pkg;

    localparam int REG_AW = 3;

    typedef logic [1:0] state_t;
    localparam state_t RUN   = 2'b00;
    localparam state_t DWAIT = 2'b01;
    localparam state_t HALT  = 2'b10;

    // Bit positions within the stall and flush vectors
    localparam int STL_IF_ID  = 0;
    localparam int STL_ID_EX  = 1;
    localparam int STL_EX_MEM = 2;
    localparam int STL_MEM_WB = 3;
    localparam int FL_IF_ID   = 0;
    localparam int FL_ID_EX   = 1;

endpackage

// File: rtl/pipe_luse_detect.sv
// Load-use comparator: the EX load targets a register the ID instruction actually reads.
// Purely combinational.
module pipe_luse_detect #(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_vld,
    input  logic              id_rt_vld,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwr,
    input  logic              ex_memrd,
    output logic              luse
);

    // r0 is deliberately not excluded: a match on it still stalls
    assign luse = ex_memrd && ex_regwr &&
                  ((id_rs_vld && (id_rs == ex_rd)) || (id_rt_vld && (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline; outputs combinational from state and inputs.
// Optional perf counters under PIPE_PERF_CNT_EN (stall_cyc, luse_cnt, flush_cnt).
module pipe_hazard_ctrl #(
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_vld,
    input  logic              id_rt_vld,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwr,
    input  logic              ex_memrd,
    input  logic              br_taken,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    input  logic              dmem_done,
    input  logic              wb_halt,
    output logic              pc_en,
    output logic              stall_if_id,
    output logic              stall_id_ex,
    output logic              stall_ex_mem,
    output logic              stall_mem_wb,
    output logic              flush_if_id,
    output logic              flush_id_ex,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cyc,
    output logic [CNT_W-1:0]  luse_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic              halted
);

    import pipe_pkg::*;

    state_t     state_q, state_d;
    logic       luse;
    logic [3:0] stall_v;
    logic [1:0] flush_v;
    logic       pc_en_c;
    logic       halted_c;

    pipe_luse_detect #(.REG_AW(REG_AW)) u_luse (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rs_vld (id_rs_vld),
        .id_rt_vld (id_rt_vld),
        .ex_rd     (ex_rd),
        .ex_regwr  (ex_regwr),
        .ex_memrd  (ex_memrd),
        .luse      (luse)
    );

    always_comb begin
        state_d  = state_q;
        stall_v  = '0;
        flush_v  = '0;
        pc_en_c  = 1'b0;
        halted_c = 1'b0;
        case (state_q)
            RUN: begin
                if (wb_halt) begin
                    state_d = HALT;
                    stall_v = '1;
                end else if (dmem_busy && !dmem_done) begin
                    state_d = DWAIT;
                    stall_v = '1;
                end else if (br_taken) begin
                    // Squashes both the in-flight fetch and any hazarding ID instruction
                    pc_en_c = 1'b1;
                    flush_v = '1;
                end else if (luse) begin
                    stall_v[STL_IF_ID] = 1'b1;
                    flush_v[FL_ID_EX]  = 1'b1;
                end else if (imem_busy) begin
                    flush_v[FL_IF_ID] = 1'b1;
                end else begin
                    pc_en_c = 1'b1;
                end
            end
            DWAIT: begin
                stall_v = '1;
                if (dmem_done)
                    state_d = RUN;
            end
            HALT: begin
                stall_v  = '1;
                halted_c = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    assign pc_en        = !rst && pc_en_c;
    assign stall_if_id  = !rst && stall_v[STL_IF_ID];
    assign stall_id_ex  = !rst && stall_v[STL_ID_EX];
    assign stall_ex_mem = !rst && stall_v[STL_EX_MEM];
    assign stall_mem_wb = !rst && stall_v[STL_MEM_WB];
    assign flush_if_id  = !rst && flush_v[FL_IF_ID];
    assign flush_id_ex  = !rst && flush_v[FL_ID_EX];
    assign halted       = !rst && halted_c;

`ifdef PIPE_PERF_CNT_EN
    logic luse_evt, br_evt, run_q;

    assign run_q    = (state_q == RUN);
    assign br_evt   = run_q && flush_v[FL_IF_ID] && flush_v[FL_ID_EX];
    assign luse_evt = run_q && flush_v[FL_ID_EX] && !flush_v[FL_IF_ID];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc <= '0;
            luse_cnt  <= '0;
            flush_cnt <= '0;
        end else if (state_q != HALT) begin
            if (!pc_en_c && (stall_cyc != '1))
                stall_cyc <= stall_cyc + CNT_W'(1);
            if (luse_evt && (luse_cnt != '1))
                luse_cnt <= luse_cnt + CNT_W'(1);
            if (br_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan sequences, then randomized traffic
// checked against a priority-rule reference model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 3;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
    logic              id_rs_vld, id_rt_vld, ex_regwr, ex_memrd;
    logic              br_taken, imem_busy, dmem_busy, dmem_done, wb_halt;
    logic              pc_en, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic              flush_if_id, flush_id_ex, halted;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cyc, luse_cnt, flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_vld    (id_rs_vld),
        .id_rt_vld    (id_rt_vld),
        .ex_rd        (ex_rd),
        .ex_regwr     (ex_regwr),
        .ex_memrd     (ex_memrd),
        .br_taken     (br_taken),
        .imem_busy    (imem_busy),
        .dmem_busy    (dmem_busy),
        .dmem_done    (dmem_done),
        .wb_halt      (wb_halt),
        .pc_en        (pc_en),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .stall_mem_wb (stall_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
`ifdef PIPE_PERF_CNT_EN
        .stall_cyc    (stall_cyc),
        .luse_cnt     (luse_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // {halted, pc_en, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex}
    logic [7:0] dut_vec;
    assign dut_vec = {halted, pc_en, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                      flush_if_id, flush_id_ex};

    localparam logic [7:0] V_ZERO  = 8'b0_0_0000_00;
    localparam logic [7:0] V_RUN   = 8'b0_1_0000_00;
    localparam logic [7:0] V_FREEZ = 8'b0_0_1111_00;
    localparam logic [7:0] V_HALT  = 8'b1_0_1111_00;
    localparam logic [7:0] V_BR    = 8'b0_1_0000_11;
    localparam logic [7:0] V_LUSE  = 8'b0_0_1000_01;
    localparam logic [7:0] V_IMEM  = 8'b0_0_0000_10;

    // Reference model: whether the processor is halted or waiting on data memory
    bit m_halted, m_waiting;
    int m_stall, m_luse, m_flush;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 none, 1 load-use bubble, 2 branch flush
    function automatic logic [7:0] expect_out(output int kind);
        bit hazard;
        kind   = 0;
        hazard = ex_memrd && ex_regwr &&
                 ((id_rs_vld && id_rs == ex_rd) || (id_rt_vld && id_rt == ex_rd));
        if (rst)                           return V_ZERO;
        if (m_halted)                      return V_HALT;
        if (m_waiting)                     return V_FREEZ;
        if (wb_halt)                       return V_FREEZ;
        if (dmem_busy && !dmem_done)       return V_FREEZ;
        if (br_taken)  begin kind = 2;     return V_BR;   end
        if (hazard)    begin kind = 1;     return V_LUSE; end
        if (imem_busy)                     return V_IMEM;
        return V_RUN;
    endfunction

    function automatic int sat(input int v);
        return (v >= (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v + 1;
    endfunction

    task automatic clock_model(input logic [7:0] e, input int kind);
        if (rst) begin
            m_halted = 0; m_waiting = 0;
            m_stall = 0; m_luse = 0; m_flush = 0;
        end else if (!m_halted) begin
            if (!e[6])     m_stall = sat(m_stall);
            if (kind == 1) m_luse  = sat(m_luse);
            if (kind == 2) m_flush = sat(m_flush);
            if (m_waiting) begin
                if (dmem_done) m_waiting = 0;
            end else if (wb_halt) begin
                m_halted = 1;
            end else if (dmem_busy && !dmem_done) begin
                m_waiting = 1;
            end
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef PIPE_PERF_CNT_EN
        chk({tag, ".stall_cyc"}, 32'(stall_cyc), 32'(m_stall));
        chk({tag, ".luse_cnt"},  32'(luse_cnt),  32'(m_luse));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic cycle(input string tag, output logic [7:0] e);
        int kind;
        #1;
        e = expect_out(kind);
        chk(tag, 32'(dut_vec), 32'(e));
        check_counters(tag);
        @(posedge clk);
        clock_model(e, kind);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_rs_vld = 0; id_rt_vld = 0; ex_regwr = 0; ex_memrd = 0;
        br_taken = 0; imem_busy = 0; dmem_busy = 0; dmem_done = 0; wb_halt = 0;
    endtask

    // Raise rst partway through the low phase; outputs must clear without waiting for an edge
    task automatic async_reset();
        int kind;
        logic [7:0] e;
        #2 rst = 1;
        #1;
        e = expect_out(kind);
        chk("async_rst", 32'(dut_vec), 32'(V_ZERO));
        @(posedge clk);
        clock_model(e, kind);
        check_counters("async_rst");
        @(negedge clk);
        rst = 0;
    endtask

    task automatic set_luse();
        ex_memrd = 1; ex_regwr = 1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_vld = 1;
    endtask

    initial begin
        logic [7:0] e;
        idle_inputs();
        rst = 1;
        m_halted = 0; m_waiting = 0; m_stall = 0; m_luse = 0; m_flush = 0;
        #2 chk("reset_outputs", 32'(dut_vec), 32'(V_ZERO));
        @(negedge clk);
        cycle("in_reset", e);
        rst = 0;
        cycle("run_idle", e);
        chk("run_idle_const", 32'(dut_vec), 32'(V_RUN));

        // Load-use: one bubble, then the hazard clears
        set_luse();
        #1 chk("luse_const", 32'(dut_vec), 32'(V_LUSE));
        cycle("luse", e);
        idle_inputs();
        set_luse(); id_rs_vld = 0;
        cycle("luse_rs_not_read", e);
        idle_inputs();
        id_rt = 3'd0; id_rt_vld = 1; ex_rd = 3'd0; ex_memrd = 1; ex_regwr = 1;
        cycle("luse_r0", e);
        idle_inputs();

        // Branch beats both load-use and imem_busy
        set_luse(); imem_busy = 1; br_taken = 1;
        #1 chk("branch_const", 32'(dut_vec), 32'(V_BR));
        cycle("branch_over_hazard", e);
        idle_inputs();

        // Single-cycle dmem access does not stall
        dmem_busy = 1; dmem_done = 1;
        cycle("dmem_single", e);

        // Four-cycle dmem wait with a held branch, serviced on cycle 5
        br_taken = 1;
        for (int i = 0; i < 4; i++) begin
            dmem_busy = 1; dmem_done = (i == 3);
            #1 chk("dwait_stalls", 32'(dut_vec), 32'(V_FREEZ));
            cycle("dwait", e);
        end
        dmem_busy = 0; dmem_done = 0;
        #1 chk("dwait_branch_after", 32'(dut_vec), 32'(V_BR));
        cycle("dwait_exit", e);
        idle_inputs();

        // Instruction-memory busy for three cycles
        for (int i = 0; i < 3; i++) begin
            imem_busy = 1;
            #1 chk("imem_busy_const", 32'(dut_vec), 32'(V_IMEM));
            cycle("imem_busy", e);
        end
        idle_inputs();

        // Halt is sticky until rst, which clears outputs asynchronously
        wb_halt = 1;
        cycle("halt_enter", e);
        wb_halt = 0;
        for (int i = 0; i < 3; i++) begin
            br_taken = (i == 1); dmem_done = (i == 2);
            #1 chk("halted_const", 32'(dut_vec), 32'(V_HALT));
            cycle("halted", e);
        end
        idle_inputs();
        async_reset();
        #1 chk("after_rst_run", 32'(dut_vec), 32'(V_RUN));
        cycle("after_rst", e);

`ifdef PIPE_PERF_CNT_EN
        // Counter scenario from a clean reset: two load-use bubbles and one branch flush
        async_reset();
        set_luse(); cycle("perf_luse1", e);
        idle_inputs(); cycle("perf_gap", e);
        set_luse(); cycle("perf_luse2", e);
        idle_inputs(); br_taken = 1; cycle("perf_br", e);
        idle_inputs(); #1;
        chk("perf_luse_cnt",  32'(luse_cnt),  32'd2);
        chk("perf_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("perf_stall_cyc", 32'(stall_cyc), 32'd2);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (m_halted && $urandom_range(0, 5) == 0) begin
                idle_inputs();
                async_reset();
                continue;
            end
            ex_rd     = REG_AW'($urandom_range(0, 7));
            id_rs     = ($urandom_range(0, 2) == 0) ? ex_rd : REG_AW'($urandom_range(0, 7));
            id_rt     = ($urandom_range(0, 2) == 0) ? ex_rd : REG_AW'($urandom_range(0, 7));
            id_rs_vld = 1'($urandom_range(0, 1));
            id_rt_vld = 1'($urandom_range(0, 1));
            ex_regwr  = ($urandom_range(0, 3) != 0);
            ex_memrd  = ($urandom_range(0, 2) == 0);
            br_taken  = ($urandom_range(0, 5) == 0);
            imem_busy = ($urandom_range(0, 3) == 0);
            dmem_busy = ($urandom_range(0, 4) == 0);
            dmem_done = ($urandom_range(0, 2) == 0);
            wb_halt   = ($urandom_range(0, 80) == 0);
            cycle("random", e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
